// File: rtl/frogger_pkg.sv
// Shared types and constants for the frog controller: FSM states, HID keycodes,
// direction encoding, grid size and screen limits, plus the hop boundary test.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOP      = 2'd1,
        ST_DEAD     = 2'd2,
        ST_GAMEOVER = 2'd3
    } frog_state_e;

    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_NONE = 8'h00;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [10:0] GRID_PX  = 11'd40;
    localparam logic [10:0] SCREEN_W = 11'd640;
    localparam logic [10:0] SCREEN_H = 11'd480;
    localparam logic [10:0] MAX_X    = SCREEN_W - GRID_PX;
    localparam logic [10:0] MAX_Y    = SCREEN_H - GRID_PX;

    // True when one full cell move from (x,y) in dir keeps the frog on screen.
    function automatic logic target_ok(input logic [10:0] x, input logic [10:0] y,
                                       input logic [1:0] dir);
        logic ok;
        case (dir)
            DIR_UP:    ok = (y >= GRID_PX);
            DIR_DOWN:  ok = ((y + GRID_PX) <= MAX_Y);
            DIR_LEFT:  ok = (x >= GRID_PX);
            DIR_RIGHT: ok = ((x + GRID_PX) <= MAX_X);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/frog_ctrl_if.sv
// Game-side bus of the frog controller: key/restart/collision inputs and the
// frog position, facing, lives, status and score outputs.
interface frog_ctrl_if;
    logic [7:0]  keycode;
    logic        Restart;
    logic        Collision;
    logic [10:0] Frog_X;
    logic [10:0] Frog_Y;
    logic [1:0]  Frog_Dir;
    logic [1:0]  Lives;
    logic        Frog_Dead;
    logic        Game_Over;
    logic [7:0]  Score;

    modport master (
        output keycode, Restart, Collision,
        input  Frog_X, Frog_Y, Frog_Dir, Lives, Frog_Dead, Game_Over, Score
    );

    modport slave (
        input  keycode, Restart, Collision,
        output Frog_X, Frog_Y, Frog_Dir, Lives, Frog_Dead, Game_Over, Score
    );
endinterface

// File: rtl/frog_ctrl_key_edge.sv
// Keycode edge detector: a movement key counts as a hop request only on the
// frame it differs from the previous frame's keycode, so a held key hops once.
module key_edge
    import frogger_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] i_keycode,
    output logic       o_hop_req,
    output logic [1:0] o_dir
);
    logic [7:0] r_prev_key;
    logic       w_is_dir;

    // Previous-frame keycode register.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_prev_key <= KEY_NONE;
        end else begin
            r_prev_key <= i_keycode;
        end
    end

    // Decode movement keys into a direction.
    always_comb begin
        w_is_dir = 1'b1;
        o_dir    = DIR_UP;
        case (i_keycode)
            KEY_W:   o_dir = DIR_UP;
            KEY_S:   o_dir = DIR_DOWN;
            KEY_A:   o_dir = DIR_LEFT;
            KEY_D:   o_dir = DIR_RIGHT;
            default: w_is_dir = 1'b0;
        endcase
    end

    assign o_hop_req = w_is_dir && (i_keycode != r_prev_key);
endmodule

// File: rtl/frog_ctrl.sv
// Frogger frog controller: hop FSM, collision/death handling, lives and score.
// Optional macro FROG_SCORE_EN enables scoring and respawn on reaching Y=0.
module frog_ctrl
    import frogger_pkg::*;
#(
    parameter logic [10:0] START_X     = 11'd320,
    parameter logic [10:0] START_Y     = 11'd440,
    parameter logic [10:0] STEP_PX     = 11'd10,
    parameter int          HOP_FRAMES  = 4,
    parameter int          DEAD_FRAMES = 60,
    parameter int          START_LIVES = 3
) (
    input  logic        frame_clk,
    input  logic        Reset,
    frog_ctrl_if.slave  bus
);
    localparam logic [7:0] HOP_LAST  = 8'(HOP_FRAMES - 1);
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_FRAMES - 1);
    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

    frog_state_e r_state, w_state_nxt;
    logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt, w_hop_x, w_hop_y;
    logic [1:0]  r_dir, w_dir_nxt, r_lives, w_lives_nxt, w_key_dir;
    logic [7:0]  r_cnt, w_cnt_nxt, r_score, w_score_nxt;
    logic        w_hop_req;

    key_edge u_key_edge (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_keycode (bus.keycode),
        .o_hop_req (w_hop_req),
        .o_dir     (w_key_dir)
    );

    // State and datapath registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_x     <= START_X;
            r_y     <= START_Y;
            r_dir   <= DIR_UP;
            r_lives <= LIVES_INIT;
            r_cnt   <= 8'd0;
            r_score <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_dir   <= w_dir_nxt;
            r_lives <= w_lives_nxt;
            r_cnt   <= w_cnt_nxt;
            r_score <= w_score_nxt;
        end
    end

    // One-step move in the current facing; bounds were checked at hop start.
    always_comb begin
        w_hop_x = r_x;
        w_hop_y = r_y;
        case (r_dir)
            DIR_UP:    w_hop_y = r_y - STEP_PX;
            DIR_DOWN:  w_hop_y = r_y + STEP_PX;
            DIR_LEFT:  w_hop_x = r_x - STEP_PX;
            DIR_RIGHT: w_hop_x = r_x + STEP_PX;
            default:   w_hop_x = r_x;
        endcase
    end

    // Next-state and datapath update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = r_cnt;
        w_score_nxt = r_score;
        case (r_state)
            ST_IDLE: begin
                if (bus.Collision) begin
                    w_state_nxt = ST_DEAD;
                    w_lives_nxt = r_lives - 2'd1;
                    w_cnt_nxt   = 8'd0;
                end else if (w_hop_req) begin
                    w_dir_nxt = w_key_dir;
                    if (target_ok(r_x, r_y, w_key_dir)) begin
                        w_state_nxt = ST_HOP;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOP: begin
                if (bus.Collision) begin
                    w_state_nxt = ST_DEAD;
                    w_lives_nxt = r_lives - 2'd1;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_x_nxt = w_hop_x;
                    w_y_nxt = w_hop_y;
                    if (r_cnt == HOP_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 8'd0;
`ifdef FROG_SCORE_EN
                        if (w_hop_y == 11'd0) begin
                            w_score_nxt = (r_score == 8'd255) ? r_score : r_score + 8'd1;
                            w_x_nxt     = START_X;
                            w_y_nxt     = START_Y;
                            w_dir_nxt   = DIR_UP;
                        end else begin
                            w_score_nxt = r_score;
                        end
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            ST_DEAD: begin
                if (r_cnt == DEAD_LAST) begin
                    w_cnt_nxt = 8'd0;
                    if (r_lives != 2'd0) begin
                        w_state_nxt = ST_IDLE;
                        w_x_nxt     = START_X;
                        w_y_nxt     = START_Y;
                        w_dir_nxt   = DIR_UP;
                    end else begin
                        w_state_nxt = ST_GAMEOVER;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_GAMEOVER: begin
                if (bus.Restart) begin
                    w_state_nxt = ST_IDLE;
                    w_lives_nxt = LIVES_INIT;
                    w_score_nxt = 8'd0;
                    w_x_nxt     = START_X;
                    w_y_nxt     = START_Y;
                    w_dir_nxt   = DIR_UP;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_GAMEOVER;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.Frog_X    = r_x;
    assign bus.Frog_Y    = r_y;
    assign bus.Frog_Dir  = r_dir;
    assign bus.Lives     = r_lives;
    assign bus.Frog_Dead = (r_state == ST_DEAD);
    assign bus.Game_Over = (r_state == ST_GAMEOVER);
`ifdef FROG_SCORE_EN
    assign bus.Score     = r_score;
`else
    assign bus.Score     = 8'd0;
`endif
endmodule

// File: doc/frog_ctrl.md
FROG_CTRL -- requirements
Module: frog_ctrl

Interface
REQ-001 Parameter START_X, default 11'd320, frog respawn X in pixels.
REQ-002 Parameter START_Y, default 11'd440, frog respawn Y in pixels (bottom row).
REQ-003 Parameter STEP_PX, default 11'd10, pixels moved per frame during a hop.
REQ-004 Parameter HOP_FRAMES, default 4, frames per hop; STEP_PX*HOP_FRAMES = 40 = one grid cell.
REQ-005 Parameter DEAD_FRAMES, default 60, frames spent in DEAD before respawn.
REQ-006 Parameter START_LIVES, default 3, lives loaded at reset and restart.
REQ-007 frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
REQ-008 Reset  in  1  asynchronous, active-high reset.
REQ-009 keycode  in  8  current USB HID keycode: W=0x1A, A=0x04, S=0x16, D=0x07, 0x00 = none.
REQ-010 Restart  in  1  level; leaves GAMEOVER when high.
REQ-011 Collision  in  1  OR of all car collision flags, evaluated against the current Frog_X/Frog_Y.
REQ-012 Frog_X, Frog_Y  out  11  frog top-left pixel position; the frog is 40x40.
REQ-013 Frog_Dir  out  2  facing: 0=up, 1=down, 2=left, 3=right.
REQ-014 Lives  out  2  remaining lives.
REQ-015 Frog_Dead  out  1  high while in DEAD.
REQ-016 Game_Over  out  1  high while in GAMEOVER.
REQ-017 Score  out  8  count of completed crossings.

Function
REQ-018 FSM states: IDLE, HOP, DEAD, GAMEOVER.
REQ-019 A hop request is a new press: keycode in {W,A,S,D} on this frame and a different keycode on the previous frame; a held key yields exactly one hop.
REQ-020 IDLE + request: set Frog_Dir; if target cell is within X 0..600 and Y 0..440, enter HOP; otherwise stay IDLE with only Frog_Dir updated.
REQ-021 HOP: move STEP_PX per frame in Frog_Dir for HOP_FRAMES frames, then return to IDLE; requests arriving during HOP are dropped.
REQ-022 Collision high in IDLE or HOP: enter DEAD next frame, freeze position, decrement Lives; collision wins over a simultaneous request or hop completion.
REQ-023 DEAD: count DEAD_FRAMES frames, ignoring Collision and keys; then, if Lives != 0, respawn at START_X/START_Y facing up in IDLE, else enter GAMEOVER.
REQ-024 GAMEOVER: position frozen; Restart high -> Lives=START_LIVES, Score=0, respawn, IDLE.
REQ-025 Arithmetic is 11-bit unsigned; boundary checks run before the move, so position never wraps.
REQ-026 Collision is combinationally derived from outputs of this block; it is sampled only on the clock edge, so no combinational loop is created.

Reset
REQ-027 Reset forces IDLE, Frog_X=START_X, Frog_Y=START_Y, Frog_Dir=0, Lives=START_LIVES, Score=0, all counters 0, and clears the previous-keycode register; this holds in any state, including mid-hop and mid-DEAD.

Configuration
REQ-028 Macro FROG_SCORE_EN present: a HOP ending at Y=0 increments Score (saturating at 255) and respawns the frog at start in the same frame.
REQ-029 Macro FROG_SCORE_EN absent: Score is tied to 0 and the frog stays at Y=0 after reaching it.

Structure
REQ-030 Package frogger_pkg holds the state enum, keycode constants, the 40-px grid constant, the 640x480 screen limits and the direction encoding.
REQ-031 Sub-module key_edge registers the previous keycode and outputs a one-frame hop request plus the decoded direction.

Verification
REQ-032 Reset, keycode 0x1A for 1 frame -> Frog_Y goes 430, 420, 410, 400 over 4 frames; Frog_Dir=0; ends in IDLE.
REQ-033 keycode 0x1A held for 20 frames -> exactly one hop; Frog_Y=400.
REQ-034 At X=600, press D -> Frog_X stays 600, Frog_Dir=3, state stays IDLE.
REQ-035 Collision pulsed during frame 2 of a hop -> position frozen, Lives 3->2, Frog_Dead high for 60 frames, then respawn at (320,440).
REQ-036 Three collisions -> Lives=0, Game_Over=1; Restart pulse -> Lives=3, IDLE at (320,440).
REQ-037 FROG_SCORE_EN set, 11 up hops with no collision -> Score=1, frog at (320,440); Reset asserted mid-hop -> immediate return to start values.
